// File: rtl/spike_encoder_if.sv
// spike_encoder_if: character stream handshake and frame abort into the spike encoder
interface spike_encoder_if;
  logic [7:0] char_in;
  logic       char_in_valid;
  logic       char_in_ready;
  logic       flush;
  modport master (output char_in, char_in_valid, flush, input char_in_ready);
  modport slave  (input char_in, char_in_valid, flush, output char_in_ready);
endinterface

// File: rtl/spike_encoder.sv
// spike_encoder: ASCII character to rate-coded 4-neuron spike frame (burst windows then silent gap)
// Define SPIKE_ENCODER_DROP_EN to add LFSR-driven stochastic spike suppression.
module spike_encoder #(
  parameter logic [4:0] WINDOW_SIZE  = 5'd16,
  parameter logic [3:0] SPIKE_PERIOD = 4'd2,
  parameter logic [3:0] REPEAT_WIN   = 4'd4,
  parameter logic [3:0] GAP_WIN      = 4'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  spike_encoder_if.slave   s_if,
  output logic [3:0]       o_spike_pattern,
  output logic             o_busy,
  output logic             o_frame_start,
  output logic             o_frame_done,
  output logic             o_bad_char
);
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t     r_state;
  logic [4:0] r_phase;
  logic [3:0] r_win;
  logic [3:0] r_pat;
  logic [3:0] w_map;
  logic       w_ok;
  logic       w_wrap;
  logic [4:0] w_nphase;
  logic [3:0] w_nwin;
  logic [3:0] w_nwins;
  logic       w_last;
  logic       w_nlast;
  logic       w_fire;
  logic       w_tail;
  logic [3:0] w_keep;

  always_comb begin
    w_ok  = 1'b1;
    w_map = 4'b0000;
    case (s_if.char_in)
      8'h41:   w_map = 4'b0001;
      8'h42:   w_map = 4'b0010;
      8'h43:   w_map = 4'b0100;
      8'h44:   w_map = 4'b1000;
      8'h45:   w_map = 4'b0011;
      8'h46:   w_map = 4'b1100;
      8'h47:   w_map = 4'b0101;
      8'h48:   w_map = 4'b1010;
      8'h20:   w_map = 4'b0000;
      default: w_ok  = 1'b0;
    endcase
  end

  assign s_if.char_in_ready = (r_state == IDLE) && !s_if.flush;

  assign w_wrap   = r_phase == WINDOW_SIZE - 5'd1;
  assign w_nphase = w_wrap ? 5'd0 : r_phase + 5'd1;
  assign w_nwin   = w_wrap ? r_win + 4'd1 : r_win;
  assign w_nwins  = (r_state == BURST) ? REPEAT_WIN : GAP_WIN;
  assign w_last   = w_wrap && (r_win == w_nwins - 4'd1);
  assign w_nlast  = (w_nphase == WINDOW_SIZE - 5'd1) && (w_nwin == w_nwins - 4'd1);
  assign w_fire   = (w_nphase % {1'b0, SPIKE_PERIOD}) == 5'd0;
  // the current state is the frame's final segment: GAP, or BURST when there is no gap
  assign w_tail   = (r_state == GAP) || (GAP_WIN == 4'd0);

`ifdef SPIKE_ENCODER_DROP_EN
  logic [7:0] r_lfsr;
  assign w_keep = {|r_lfsr[7:6], |r_lfsr[5:4], |r_lfsr[3:2], |r_lfsr[1:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_lfsr <= 8'hA5;
    else if (r_state == BURST) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
`else
  assign w_keep = 4'hF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_phase         <= 5'd0;
      r_win           <= 4'd0;
      r_pat           <= 4'd0;
      o_spike_pattern <= 4'd0;
      o_busy          <= 1'b0;
      o_frame_start   <= 1'b0;
      o_frame_done    <= 1'b0;
      o_bad_char      <= 1'b0;
    end else if (r_state == IDLE) begin
      o_frame_done  <= 1'b0;
      o_frame_start <= 1'b0;
      o_bad_char    <= 1'b0;
      if (s_if.char_in_valid && s_if.char_in_ready) begin
        if (w_ok) begin
          r_state         <= BURST;
          r_pat           <= w_map;
          r_phase         <= 5'd0;
          r_win           <= 4'd0;
          o_spike_pattern <= w_map & w_keep;
          o_busy          <= 1'b1;
          o_frame_start   <= 1'b1;
        end else begin
          o_bad_char <= 1'b1;
        end
      end
    end else if (s_if.flush || (w_last && w_tail)) begin
      r_state         <= IDLE;
      r_phase         <= 5'd0;
      r_win           <= 4'd0;
      o_spike_pattern <= 4'd0;
      o_busy          <= 1'b0;
      o_frame_start   <= 1'b0;
      o_frame_done    <= 1'b0;
    end else if (w_last) begin
      r_state         <= GAP;
      r_phase         <= 5'd0;
      r_win           <= 4'd0;
      o_spike_pattern <= 4'd0;
      o_frame_start   <= 1'b0;
      o_frame_done    <= 1'b0;
    end else begin
      r_phase         <= w_nphase;
      r_win           <= w_nwin;
      o_spike_pattern <= (r_state == BURST && w_fire) ? r_pat & w_keep : 4'd0;
      o_frame_start   <= 1'b0;
      o_frame_done    <= w_tail && w_nlast;
    end
  end
endmodule
